control_unit: RTL and testbench

Decode-stage control unit of the five-stage ARM pipeline. Decodes the instruction `mode` field, the 4-bit `opcode` and the `S` bit into the execute command, the status-update request and the branch, memory and write-back enables. These are captured in an output register that feeds the ID/EX boundary. Hazard stalls convert the captured instruction into a bubble.

---
 rtl/control_unit.sv | 137 +++++++++++++
 tb/tb_control_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// rtl/control_unit.sv - decode-stage control unit with registered ID/EX control word
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   mode[1:0]       instruction class (00 dp, 01 mem, 10 branch, 11 reserved)
//   opcode[3:0]     data-processing opcode
//   S               S bit; for memory class 1 = LDR, 0 = STR
//   stall           load a bubble instead of the decoded word
//   S_UpdateSig, branch, exeCMD[3:0], memWriteEn, memReadEn, writeBackEn
//                   registered control outputs
//   illegal         registered undefined-encoding flag
//
// Build option: CU_ILLEGAL_DETECT_EN enables the illegal flag; otherwise it is 0.

module control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic [3:0] opcode,
    input  logic       S,
    input  logic       stall,
    output logic       S_UpdateSig,
    output logic       branch,
    output logic [3:0] exeCMD,
    output logic       memWriteEn,
    output logic       memReadEn,
    output logic       writeBackEn,
    output logic       illegal
);

`ifdef CU_ILLEGAL_DETECT_EN
    localparam logic ILLEGAL_EN = 1'b1;
`else
    localparam logic ILLEGAL_EN = 1'b0;
`endif

    logic       d_s_update;
    logic       d_branch;
    logic [3:0] d_exe_cmd;
    logic       d_mem_write;
    logic       d_mem_read;
    logic       d_write_back;
    logic       d_illegal;

    always_comb begin
        d_s_update   = 1'b0;
        d_branch     = 1'b0;
        d_exe_cmd    = 4'b0000;
        d_mem_write  = 1'b0;
        d_mem_read   = 1'b0;
        d_write_back = 1'b0;
        d_illegal    = 1'b0;

        case (mode)
            2'b00: begin
                d_s_update   = S;
                d_write_back = 1'b1;
                case (opcode)
                    4'b1101: d_exe_cmd = 4'b0001;
                    4'b1111: d_exe_cmd = 4'b1001;
                    4'b0100: d_exe_cmd = 4'b0010;
                    4'b0101: d_exe_cmd = 4'b0011;
                    4'b0010: d_exe_cmd = 4'b0100;
                    4'b0110: d_exe_cmd = 4'b0101;
                    4'b0000: d_exe_cmd = 4'b0110;
                    4'b1100: d_exe_cmd = 4'b0111;
                    4'b0001: d_exe_cmd = 4'b1000;
                    // Compare/test only set flags; no register result.
                    4'b1010: begin
                        d_exe_cmd    = 4'b0100;
                        d_s_update   = 1'b1;
                        d_write_back = 1'b0;
                    end
                    4'b1000: begin
                        d_exe_cmd    = 4'b0110;
                        d_s_update   = 1'b1;
                        d_write_back = 1'b0;
                    end
                    default: begin
                        d_s_update   = 1'b0;
                        d_write_back = 1'b0;
                        d_illegal    = 1'b1;
                    end
                endcase
            end
            2'b01: begin
                if (opcode == 4'b0100) begin
                    d_exe_cmd = 4'b0010;
                    if (S) begin
                        d_mem_read   = 1'b1;
                        d_write_back = 1'b1;
                    end else begin
                        d_mem_write  = 1'b1;
                    end
                end else begin
                    d_illegal = 1'b1;
                end
            end
            2'b10: begin
                d_branch = 1'b1;
            end
            default: begin
                d_illegal = 1'b1;
            end
        endcase
    end

    // A stall overrides the decode with an all-zero bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_UpdateSig <= 1'b0;
            branch      <= 1'b0;
            exeCMD      <= 4'b0000;
            memWriteEn  <= 1'b0;
            memReadEn   <= 1'b0;
            writeBackEn <= 1'b0;
            illegal     <= 1'b0;
        end else if (stall) begin
            S_UpdateSig <= 1'b0;
            branch      <= 1'b0;
            exeCMD      <= 4'b0000;
            memWriteEn  <= 1'b0;
            memReadEn   <= 1'b0;
            writeBackEn <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            S_UpdateSig <= d_s_update;
            branch      <= d_branch;
            exeCMD      <= d_exe_cmd;
            memWriteEn  <= d_mem_write;
            memReadEn   <= d_mem_read;
            writeBackEn <= d_write_back;
            illegal     <= d_illegal & ILLEGAL_EN;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit

module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic [3:0] opcode;
    logic       S;
    logic       stall;
    logic       S_UpdateSig;
    logic       branch;
    logic [3:0] exeCMD;
    logic       memWriteEn;
    logic       memReadEn;
    logic       writeBackEn;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    // Reference table: ALU command per data-processing opcode, -1 = undefined.
    int dp_cmd [16];
    bit dp_flags_only [16];

`ifdef CU_ILLEGAL_DETECT_EN
    localparam bit ILL_ON = 1'b1;
`else
    localparam bit ILL_ON = 1'b0;
`endif

    control_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .opcode      (opcode),
        .S           (S),
        .stall       (stall),
        .S_UpdateSig (S_UpdateSig),
        .branch      (branch),
        .exeCMD      (exeCMD),
        .memWriteEn  (memWriteEn),
        .memReadEn   (memReadEn),
        .writeBackEn (writeBackEn),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word layout: {S_Upd, branch, exeCMD[3:0], memW, memR, WB, illegal}
    function automatic logic [9:0] pack(bit su, bit br, int cmd, bit mw, bit mr, bit wb, bit il);
        logic [3:0] c;
        c = cmd[3:0];
        return {su, br, c, mw, mr, wb, il & ILL_ON};
    endfunction

    function automatic logic [9:0] model(int m, int op, bit s, bit stl);
        if (stl) return '0;
        if (m == 0) begin
            if (dp_cmd[op] < 0) return pack(0, 0, 0, 0, 0, 0, 1);
            if (dp_flags_only[op]) return pack(1, 0, dp_cmd[op], 0, 0, 0, 0);
            return pack(s, 0, dp_cmd[op], 0, 0, 1, 0);
        end
        if (m == 1) begin
            if (op != 4) return pack(0, 0, 0, 0, 0, 0, 1);
            return s ? pack(0, 0, 2, 0, 1, 1, 0) : pack(0, 0, 2, 1, 0, 0, 0);
        end
        if (m == 2) return pack(0, 1, 0, 0, 0, 0, 0);
        return pack(0, 0, 0, 0, 0, 0, 1);
    endfunction

    function automatic logic [9:0] observed();
        return {S_UpdateSig, branch, exeCMD, memWriteEn, memReadEn, writeBackEn, illegal};
    endfunction

    task automatic check(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive inputs shortly after an edge, then sample 1 time unit after the next edge.
    task automatic step(input string tag, input int m, input int op, input bit s, input bit stl);
        mode   = m[1:0];
        opcode = op[3:0];
        S      = s;
        stall  = stl;
        @(posedge clk);
        #1;
        check(tag, model(m, op, s, stl));
    endtask

    initial begin
        logic [9:0] held;
        int         legal_ops [11];
        int         m, op;
        bit         s, stl;

        for (int i = 0; i < 16; i++) begin
            dp_cmd[i] = -1;
            dp_flags_only[i] = 1'b0;
        end
        dp_cmd[13] = 1; dp_cmd[15] = 9; dp_cmd[4] = 2; dp_cmd[5] = 3;
        dp_cmd[2]  = 4; dp_cmd[6]  = 5; dp_cmd[0] = 6; dp_cmd[12] = 7;
        dp_cmd[1]  = 8; dp_cmd[10] = 4; dp_cmd[8] = 6;
        dp_flags_only[10] = 1'b1;
        dp_flags_only[8]  = 1'b1;
        legal_ops = '{13, 15, 4, 5, 2, 6, 0, 12, 1, 10, 8};

        // Reset with a legal MOV applied: outputs zero before any edge.
        rst_n = 1'b0; mode = 2'b00; opcode = 4'b1101; S = 1'b0; stall = 1'b0;
        #2;
        check("reset_pre_edge", '0);
        @(posedge clk); #1;
        check("reset_held_edge", '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_capture_mov", pack(0, 0, 1, 0, 0, 1, 0));

        // Named directed cases.
        step("mov_s1", 0, 13, 1, 0);
        step("sub_s0", 0, 2, 0, 0);
        step("cmp_s0", 0, 10, 0, 0);
        foreach (legal_ops[i]) begin
            step($sformatf("dp_op%0d_s0", legal_ops[i]), 0, legal_ops[i], 0, 0);
            step($sformatf("dp_op%0d_s1", legal_ops[i]), 0, legal_ops[i], 1, 0);
        end
        step("ldr", 1, 4, 1, 0);
        step("str", 1, 4, 0, 0);
        step("branch", 2, 0, 0, 0);
        step("branch_s1", 2, 9, 1, 0);
        step("ill_dp_0011", 0, 3, 0, 0);
        step("ill_mode11", 3, 4, 1, 0);
        step("ill_mem_op0", 1, 0, 1, 0);
        step("stall_add", 0, 4, 1, 1);
        step("unstall_add", 0, 4, 1, 0);
        step("stall_illegal", 3, 0, 0, 1);

        // Inputs changing between edges must not disturb the held outputs.
        step("hold_setup_ldr", 1, 4, 1, 0);
        held = observed();
        mode = 2'b10; opcode = 4'b0011; S = 1'b0; stall = 1'b1;
        #2;
        check("hold_between_edges", held);

        // Mid-operation reset clears immediately.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_mid", '0);
        @(negedge clk);
        rst_n = 1'b1;
        step("after_reset_b", 2, 0, 0, 0);

        // Randomized sweep against the table model.
        for (int n = 0; n < 300; n++) begin
            m   = int'($urandom_range(0, 3));
            op  = int'($urandom_range(0, 15));
            s   = 1'($urandom_range(0, 1));
            stl = ($urandom_range(0, 4) == 0);
            step($sformatf("rand%0d_m%0d_op%0d_s%0d_st%0d", n, m, op, s, stl), m, op, s, stl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
